// File: rtl/timer_dev.sv
// Programmable count-down timer on the processor I/O bus.
// Software programs PRESET and CTRL; the timer counts PRESET down to zero,
// raises a pending interrupt and either stops (mode 0) or reloads (mode 1).
module timer_dev #(
  parameter int unsigned DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t         r_state;
  logic [3:0]     r_ctrl;      // {IM, MODE[1:0], EN}
  logic [31:0]    r_preset;
  logic [31:0]    r_count;
  logic [PW-1:0]  r_presc;
  logic           r_pend;
  logic           r_irq;

  logic           w_ctrl_we;
  logic           w_preset_we;
  logic           w_en;
  logic           w_mode1;
  logic           w_tick;

  assign w_ctrl_we   = we && (addr == 2'd0);
  assign w_preset_we = we && (addr == 2'd1);
  assign w_en        = r_ctrl[0];
  // MODE values 2 and 3 fall back to one-shot behaviour
  assign w_mode1     = (r_ctrl[2:1] == 2'b01);
  assign w_tick      = (r_presc == PW'(DIV - 1));

  // PRESET register: plain software R/W, sampled only when the FSM reloads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_preset <= 32'd0;
    end else if (w_preset_we) begin
      r_preset <= wd;
    end
  end

  // Timer FSM with CTRL, COUNT, prescaler and pending flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ctrl  <= 4'd0;
      r_count <= 32'd0;
      r_presc <= '0;
      r_pend  <= 1'b0;
    end else begin
      // software write first; FSM assignments below override where they must
      if (w_ctrl_we) begin
        r_ctrl <= wd[3:0];
        r_pend <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_en) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_presc <= '0;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!w_en) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            r_presc <= '0;
            // zero preset expires on its first tick instead of wrapping
            if (r_count > 32'd1) begin
              r_count <= r_count - 32'd1;
            end else begin
              r_count <= 32'd0;
              r_pend  <= 1'b1;
              r_state <= S_INT;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        S_INT: begin
          if (w_mode1) begin
            r_pend  <= 1'b0;
            r_state <= S_LOAD;
          end else begin
            // a CTRL write in this cycle keeps its EN and cannot clear pending
            r_pend  <= 1'b1;
            if (!w_ctrl_we) r_ctrl[0] <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered interrupt request, one cycle behind pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_ctrl[3] & r_pend;
    end
  end

  assign irq = r_irq;

  // Combinational read mux
  always_comb begin
    rd = 32'd0;
    case (addr)
      2'd0:    rd = {28'd0, r_ctrl};
      2'd1:    rd = r_preset;
      2'd2:    rd = r_count;
      default: rd = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: two instances (DIV=1 and DIV=4) share the bus inputs
// and are compared every cycle against a timeline-based model, plus
// hand-computed spot checks.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd1, rd4;
  logic        irq1, irq4;

  int total = 0;
  int bad   = 0;

  timer_dev #(.DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wd(wd), .rd(rd1), .irq(irq1)
  );
  timer_dev #(.DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wd(wd), .rd(rd4), .irq(irq4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: timer described by timestamps ----------------
  longint      cyc = 0;
  logic [3:0]  m_ctrl   [2] = '{4'd0, 4'd0};
  logic [31:0] m_preset [2] = '{32'd0, 32'd0};
  logic [31:0] m_count  [2] = '{32'd0, 32'd0};
  logic        m_pend   [2] = '{1'b0, 1'b0};
  logic        m_irq    [2] = '{1'b0, 1'b0};
  logic        m_run    [2] = '{1'b0, 1'b0};   // enabled run in progress
  logic        m_exp    [2] = '{1'b0, 1'b0};   // previous edge expired the count
  longint      m_load_at[2] = '{0, 0};         // edge at which count gets PRESET
  longint      m_t0     [2] = '{0, 0};
  longint      m_n      [2] = '{0, 0};
  longint      m_int_at [2] = '{0, 0};         // edge at which count reaches 0

  function automatic longint divof(input int k);
    return (k == 0) ? 64'sd1 : 64'sd4;
  endfunction

  task automatic mreset(input int k);
    m_ctrl[k] = 4'd0; m_preset[k] = 32'd0; m_count[k] = 32'd0;
    m_pend[k] = 1'b0; m_irq[k] = 1'b0; m_run[k] = 1'b0; m_exp[k] = 1'b0;
  endtask

  task automatic mstep(input int k);
    logic [3:0]  c0;
    logic        p0, en, mode1, cw, set_p, clr_p, en_clr;
    logic [31:0] pr0;
    longint      ticks, dv;
    c0 = m_ctrl[k]; p0 = m_pend[k]; pr0 = m_preset[k];
    en = c0[0]; mode1 = (c0[2:1] == 2'b01);
    cw = we && (addr == 2'd0);
    set_p = 1'b0; clr_p = 1'b0; en_clr = 1'b0;
    dv = divof(k);
    m_irq[k] = c0[3] & p0;
    if (m_exp[k]) begin
      m_exp[k] = 1'b0;
      if (mode1) begin
        m_load_at[k] = cyc + 1;
        clr_p = 1'b1;
      end else begin
        m_run[k] = 1'b0;
        en_clr = 1'b1;
        set_p = 1'b1;
      end
    end else if (!m_run[k]) begin
      if (en) begin
        m_run[k] = 1'b1;
        m_load_at[k] = cyc + 1;
      end
    end else if (cyc == m_load_at[k]) begin
      m_n[k] = longint'(pr0);
      m_t0[k] = cyc;
      m_int_at[k] = cyc + ((pr0 == 32'd0) ? 64'sd1 : longint'(pr0)) * dv;
      m_count[k] = pr0;
    end else if (!en) begin
      m_run[k] = 1'b0;
    end else begin
      ticks = (cyc - m_t0[k]) / dv;
      m_count[k] = (ticks >= m_n[k]) ? 32'd0 : 32'(m_n[k] - ticks);
      if (cyc == m_int_at[k]) begin
        m_exp[k] = 1'b1;
        set_p = 1'b1;
      end
    end
    if (set_p)      m_pend[k] = 1'b1;
    else if (clr_p) m_pend[k] = 1'b0;
    else if (cw)    m_pend[k] = 1'b0;
    if (cw)          m_ctrl[k] = wd[3:0];
    else if (en_clr) m_ctrl[k][0] = 1'b0;
    if (we && addr == 2'd1) m_preset[k] = wd;
  endtask

  function automatic logic [31:0] mrd(input int k);
    case (addr)
      2'd0:    return {28'd0, m_ctrl[k]};
      2'd1:    return m_preset[k];
      2'd2:    return m_count[k];
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mreset(0);
        mreset(1);
      end else begin
        cyc = cyc + 1;
        mstep(0);
        mstep(1);
      end
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_div1",  rd1,  mrd(0));
      chk("irq_div1", {31'd0, irq1}, {31'd0, m_irq[0]});
      chk("rd_div4",  rd4,  mrd(1));
      chk("irq_div4", {31'd0, irq4}, {31'd0, m_irq[1]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    @(posedge clk);
    #2;
    we = 1'b0; addr = 2'd2; wd = 32'd0;
  endtask

  task automatic peek(input string nm, input logic [1:0] a, input int k, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, (k == 0) ? rd1 : rd4, exp);
    addr = 2'd2;
  endtask

  logic [31:0] seq_cnt [6] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3};
  logic        seq_irq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b0; we = 1'b0; addr = 2'd2; wd = 32'd0;
    idle(3);
    chk("reset_irq", {31'd0, irq1}, 32'd0);
    chk("reset_count", rd1, 32'd0);
    peek("reset_ctrl", 2'd0, 0, 32'd0);
    rst = 1'b1;
    idle(2);

    // one-shot, PRESET=5: irq 8 edges after the CTRL write
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    idle(7);
    chk("os_irq_e7", {31'd0, irq1}, 32'd0);
    idle(1);
    chk("os_irq_e8", {31'd0, irq1}, 32'd1);
    chk("os_count0", rd1, 32'd0);
    peek("os_ctrl_en_cleared", 2'd0, 0, 32'h8);
    idle(3);
    chk("os_irq_held", {31'd0, irq1}, 32'd1);
    wr(2'd0, 32'h0);
    idle(1);
    chk("os_irq_cleared", {31'd0, irq1}, 32'd0);
    idle(4);

    // auto-reload, PRESET=3: period 5
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      chk("ar_count_seq", rd1, seq_cnt[i]);
      chk("ar_irq_seq", {31'd0, irq1}, {31'd0, seq_irq[i]});
      idle(1);
    end
    idle(3);
    chk("ar_irq_2nd_pulse", {31'd0, irq1}, 32'd1);
    wr(2'd0, 32'h0);
    idle(4);

    // PRESET=0 expires on the first tick
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    idle(2);
    chk("zero_count", rd1, 32'd0);
    idle(1);
    chk("zero_irq_e3", {31'd0, irq1}, 32'd0);
    idle(1);
    chk("zero_irq_e4", {31'd0, irq1}, 32'd1);
    wr(2'd0, 32'h0);
    idle(4);

    // PRESET rewrite during count does not restart the run
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    idle(5);
    wr(2'd1, 32'd10);
    idle(16);
    chk("norestart_irq_e22", {31'd0, irq1}, 32'd0);
    idle(1);
    chk("norestart_irq_e23", {31'd0, irq1}, 32'd1);
    peek("norestart_preset", 2'd1, 0, 32'd10);
    wr(2'd0, 32'h0);
    idle(4);

    // DIV=4: freeze on disable, reload on re-enable
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    idle(6);
    chk("div4_count_e6", rd4, 32'd1);
    wr(2'd0, 32'h0);
    idle(5);
    chk("div4_frozen", rd4, 32'd1);
    wr(2'd0, 32'h1);
    idle(2);
    chk("div4_reload", rd4, 32'd2);
    wr(2'd0, 32'h0);
    idle(4);

    // CTRL write during the one-shot expiry cycle keeps EN and pending
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    idle(4);
    wr(2'd0, 32'h9);
    chk("int_wr_irq", {31'd0, irq1}, 32'd1);
    peek("int_wr_ctrl", 2'd0, 0, 32'h9);
    idle(2);
    chk("int_wr_reload", rd1, 32'd2);
    chk("int_wr_irq_kept", {31'd0, irq1}, 32'd1);
    idle(3);
    peek("int_wr_ctrl_after", 2'd0, 0, 32'h8);
    wr(2'd0, 32'h0);
    idle(1);
    chk("int_wr_irq_clr", {31'd0, irq1}, 32'd0);
    idle(3);

    // reset in the middle of a long count
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    idle(39);
    chk("mid_count_e39", rd1, 32'd63);
    rst = 1'b0;
    #1;
    chk("rst_irq1", {31'd0, irq1}, 32'd0);
    chk("rst_irq4", {31'd0, irq4}, 32'd0);
    chk("rst_count", rd1, 32'd0);
    peek("rst_preset", 2'd1, 0, 32'd0);
    idle(2);
    rst = 1'b1;
    idle(5);
    chk("post_rst_count", rd1, 32'd0);
    peek("post_rst_ctrl", 2'd0, 0, 32'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
